// File: rtl/linear_pkg.sv
// Shared definitions for the tiled linear layer: FSM states, accumulator sizing, saturation bounds
// and the round/saturate helper. Define LINEAR_ROUND_EN for round-half-up instead of floor.
package linear_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN
    } state_t;

    // Smallest accumulator that cannot wrap over a full dot product plus bias.
    function automatic int unsigned acc_width_min(input int unsigned dw, input int unsigned in_dim);
        return 2 * dw + $clog2(in_dim) + 1;
    endfunction

    function automatic logic signed [63:0] sat_max(input int unsigned dw);
        logic signed [63:0] one;
        one = 64'sd1;
        return (one <<< (dw - 1)) - one;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned dw);
        logic signed [63:0] one;
        one = 64'sd1;
        return -(one <<< (dw - 1));
    endfunction

    function automatic logic signed [63:0] round_sat(input  logic signed [63:0] acc,
                                                     input  int unsigned        frac,
                                                     input  int unsigned        dw,
                                                     output logic               clip);
        logic signed [63:0] v;
        v = acc;
`ifdef LINEAR_ROUND_EN
        if (frac > 0) v = v + (64'sd1 <<< (frac - 1));
`endif
        v = v >>> frac;
        clip = (v > sat_max(dw)) || (v < sat_min(dw));
        if (v > sat_max(dw)) return sat_max(dw);
        if (v < sat_min(dw)) return sat_min(dw);
        return v;
    endfunction

endpackage

// File: rtl/linear_mac_lane.sv
// One MAC lane: registered product, bias-initialised accumulator, round/saturate to an output
// register. Rounding follows LINEAR_ROUND_EN through linear_pkg::round_sat.
module linear_mac_lane
    import linear_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  mul_en,
    input  logic                  acc_en,
    input  logic                  res_en,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] w,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  clip
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [63:0]             res;

    always_ff @(posedge clk) begin
        if (mul_en) prod <= $signed(x) * $signed(w);
        if (init)        acc <= ACC_WIDTH'($signed(bias)) <<< FRAC_BITS;
        else if (acc_en) acc <= acc + ACC_WIDTH'(prod);
        if (rst)         y <= '0;
        else if (res_en) y <= DATA_WIDTH'(res);
    end

    // clip reflects the current accumulator; the top only samples it on res_en.
    always_comb res = round_sat(64'(acc), FRAC_BITS, DATA_WIDTH, clip);

endmodule

// File: rtl/linear_layer_tiled.sv
// Tiled fixed-point fully-connected layer y = x*W + b with LANES parallel MAC lanes.
// Build option: LINEAR_ROUND_EN (round half up before the fractional shift; default floor).
module linear_layer_tiled
    import linear_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned IN_DIM     = 256,
    parameter int unsigned OUT_DIM    = 512,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 ovf,
    input  logic                                 wr_en,
    input  logic                                 wr_is_bias,
    input  logic [$clog2(IN_DIM*OUT_DIM)-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES*DATA_WIDTH-1:0]          out_data,
    output logic [((OUT_DIM/LANES) > 1 ? $clog2(OUT_DIM/LANES) : 1)-1:0] out_tile,
    output logic                                 out_last
);

    localparam int unsigned NTILE  = OUT_DIM / LANES;
    localparam int unsigned WWORDS = IN_DIM * NTILE;
    localparam int unsigned AW     = $clog2(IN_DIM * OUT_DIM);
    localparam int unsigned WAW    = $clog2(WWORDS);
    localparam int unsigned TW     = (NTILE > 1) ? $clog2(NTILE) : 1;
    localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned IW     = $clog2(IN_DIM);
    localparam int unsigned KW     = $clog2(IN_DIM + 3);
    localparam int unsigned ACC_W  = (ACC_WIDTH > acc_width_min(DATA_WIDTH, IN_DIM)) ?
                                     ACC_WIDTH : acc_width_min(DATA_WIDTH, IN_DIM);

    state_t state, state_nx;

    logic [LANES-1:0][DATA_WIDTH-1:0] w_ram [WWORDS];
    logic [LANES-1:0][DATA_WIDTH-1:0] b_ram [NTILE];
    logic [DATA_WIDTH-1:0]            x_mem [IN_DIM];

    logic [LANES-1:0][DATA_WIDTH-1:0] w_rd, b_rd;
    logic [DATA_WIDTH-1:0]            x_rd;
    logic [WAW-1:0]                   wr_word, rd_word;
    logic [TW-1:0]                    wr_bword, tile;
    logic [LW-1:0]                    wr_lane;
    logic [IW-1:0]                    in_cnt;
    logic [KW-1:0]                    k;
    logic                             rd_v, mul_v, init_c, res_en;
    logic [LANES-1:0]                 clip;

    always_comb begin
        wr_word  = WAW'(wr_addr / AW'(LANES));
        wr_bword = TW'(wr_addr / AW'(LANES));
        wr_lane  = LW'(wr_addr % AW'(LANES));
        // Tile t, input i needs elements i*OUT_DIM + t*LANES + l, which share one RAM word.
        rd_word  = WAW'(k) * WAW'(NTILE) + WAW'(tile);
        b_rd     = b_ram[tile];
    end

    always_ff @(posedge clk) begin
        if (wr_en && state == ST_IDLE) begin
            if (wr_is_bias) b_ram[wr_bword][wr_lane] <= wr_data;
            else            w_ram[wr_word][wr_lane]  <= wr_data;
        end
        if (in_ready && in_valid) x_mem[in_cnt] <= in_data;
        if (state == ST_COMPUTE && k < KW'(IN_DIM)) begin
            x_rd <= x_mem[IW'(k)];
            w_rd <= w_ram[rd_word];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start) state_nx = ST_LOAD;
            ST_LOAD:    if (in_valid && in_cnt == IW'(IN_DIM - 1)) state_nx = ST_COMPUTE;
            ST_COMPUTE: if (k == KW'(IN_DIM + 2)) state_nx = ST_DRAIN;
            ST_DRAIN:   if (out_ready) state_nx = out_last ? ST_IDLE : ST_COMPUTE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        in_ready  = (state == ST_LOAD);
        out_valid = (state == ST_DRAIN);
        out_last  = out_valid && (tile == TW'(NTILE - 1));
        init_c    = (state == ST_COMPUTE) && (k == '0);
        res_en    = (state == ST_COMPUTE) && (k == KW'(IN_DIM + 2));
        out_tile  = tile;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v   <= 1'b0;
            mul_v  <= 1'b0;
            in_cnt <= '0;
            k      <= '0;
            tile   <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            rd_v  <= (state == ST_COMPUTE) && (k < KW'(IN_DIM));
            mul_v <= rd_v;
            done  <= out_valid && out_ready && out_last;
            case (state)
                ST_IDLE: if (start) begin
                    in_cnt <= '0;
                    k      <= '0;
                    tile   <= '0;
                    ovf    <= 1'b0;
                end
                ST_LOAD: if (in_valid) in_cnt <= in_cnt + 1'b1;
                ST_COMPUTE: begin
                    k <= k + 1'b1;
                    if (res_en && |clip) ovf <= 1'b1;
                end
                ST_DRAIN: if (out_ready) begin
                    k <= '0;
                    if (!out_last) tile <= tile + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        linear_mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .ACC_WIDTH (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .init  (init_c),
            .mul_en(rd_v),
            .acc_en(mul_v),
            .res_en(res_en),
            .bias  (b_rd[l]),
            .x     (x_rd),
            .w     (w_rd[l]),
            .y     (out_data[(l+1)*DATA_WIDTH-1 -: DATA_WIDTH]),
            .clip  (clip[l])
        );
    end

endmodule

// File: tb/tb_linear_layer_tiled.sv
// Directed bench for linear_layer_tiled at IN_DIM=2, OUT_DIM=4, LANES=2, Q8.8.
// Expected values are hand-computed; rounding-dependent expectations follow LINEAR_ROUND_EN.
module tb_linear_layer_tiled;

    logic        clk = 1'b0;
    logic        rst, start, wr_en, wr_is_bias, in_valid, out_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data, in_data;
    logic        busy, done, ovf, in_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [0:0]  out_tile;

    int checks = 0;
    int errors = 0;

`ifdef LINEAR_ROUND_EN
    localparam logic [15:0] RND_POS = 16'h0001;
    localparam logic [15:0] RND_NEG = 16'h0000;
`else
    localparam logic [15:0] RND_POS = 16'h0000;
    localparam logic [15:0] RND_NEG = 16'hFFFF;
`endif

    logic [15:0] c1_w [8] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0000,
                              16'h0100, 16'h0000, 16'h0100, 16'h0400};
    logic [15:0] c1_b [4] = '{16'h0010, 16'h0000, 16'h0000, 16'hFF00};

    always #5 clk = ~clk;

    linear_layer_tiled #(
        .DATA_WIDTH(16),
        .FRAC_BITS (8),
        .IN_DIM    (2),
        .OUT_DIM   (4),
        .LANES     (2),
        .ACC_WIDTH (40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .wr_en     (wr_en),
        .wr_is_bias(wr_is_bias),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tile  (out_tile),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic bias, input int addr, input logic [15:0] data);
        wr_en = 1'b1; wr_is_bias = bias; wr_addr = 3'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic set_case1();
        for (int i = 0; i < 8; i++) wr(1'b0, i, c1_w[i]);
        for (int i = 0; i < 4; i++) wr(1'b1, i, c1_b[i]);
    endtask

    // Pulses start (optionally with a same-cycle write), loads x0,x1, waits for first out_valid.
    task automatic start_load(input logic [15:0] x0, input logic [15:0] x1,
                              input logic sw, input int sw_addr, input logic [15:0] sw_data,
                              input logic poke);
        int lat;
        start = 1'b1; in_valid = 1'b1; in_data = x0;
        wr_en = sw; wr_is_bias = 1'b1; wr_addr = 3'(sw_addr); wr_data = sw_data;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                in_data = x1;
                if (poke) begin
                    start = 1'b1; wr_en = 1'b1; wr_is_bias = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
                end
            end
            if (lat == 2) begin
                in_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
            end
        end
        chk("first_valid_latency", 32'(lat), 32'd7);
    endtask

    task automatic take_tile(input logic [31:0] exp_data, input logic exp_tile,
                             input logic exp_last, input int hold);
        int n;
        int bad;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tile_valid", 32'(out_valid), 32'd1);
        if (hold > 0) begin
            bad = 0;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || out_data !== exp_data || out_tile !== exp_tile) bad++;
            end
            chk("backpressure_stable", 32'(bad), 32'd0);
        end
        chk("tile_data", out_data, exp_data);
        chk("tile_index", 32'(out_tile), 32'(exp_tile));
        chk("tile_last", 32'(out_last), 32'(exp_last));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic end_run(input logic exp_ovf);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic run_case1(input logic poke, input int hold);
        start_load(16'h0100, 16'h0080, 1'b0, 0, 16'h0000, poke);
        take_tile(32'h0200_0190, 1'b0, 1'b0, hold);
        take_tile(32'h0100_FF80, 1'b1, 1'b1, 0);
        end_run(1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_is_bias = 1'b0; wr_addr = '0;
        wr_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_tile", 32'(out_tile), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic functional case.
        set_case1();
        run_case1(1'b0, 0);

        // Positive and negative saturation.
        for (int i = 0; i < 8; i++) wr(1'b0, i, 16'h0400);
        for (int i = 0; i < 4; i++) wr(1'b1, i, 16'h0000);
        start_load(16'h7F00, 16'h7F00, 1'b0, 0, 16'h0000, 1'b0);
        take_tile(32'h7FFF_7FFF, 1'b0, 1'b0, 0);
        take_tile(32'h7FFF_7FFF, 1'b1, 1'b1, 0);
        end_run(1'b1);
        start_load(16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b0);
        take_tile(32'h8000_8000, 1'b0, 1'b0, 0);
        take_tile(32'h8000_8000, 1'b1, 1'b1, 0);
        end_run(1'b1);

        // Rounding boundary; b[3] rewritten to 0 in the start cycle, ovf cleared by start.
        for (int i = 0; i < 8; i++) wr(1'b0, i, 16'h0080);
        wr(1'b1, 3, 16'hFF00);
        start_load(16'h0001, 16'h0000, 1'b1, 3, 16'h0000, 1'b0);
        take_tile({RND_POS, RND_POS}, 1'b0, 1'b0, 0);
        take_tile({RND_POS, RND_POS}, 1'b1, 1'b1, 0);
        end_run(1'b0);
        start_load(16'hFFFF, 16'h0000, 1'b0, 0, 16'h0000, 1'b0);
        take_tile({RND_NEG, RND_NEG}, 1'b0, 1'b0, 0);
        take_tile({RND_NEG, RND_NEG}, 1'b1, 1'b1, 0);
        end_run(1'b0);

        // start/wr_en while busy are ignored; next run confirms W[0] was untouched.
        set_case1();
        run_case1(1'b1, 0);
        run_case1(1'b0, 20);

        // Reset mid-COMPUTE, then rerun.
        start = 1'b1; in_valid = 1'b1; in_data = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_data = 16'h0080;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_compute_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_done", 32'(done), 32'd0);
        run_case1(1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
